// File: rtl/msg_display_scanner_if.sv
// rtl/msg_display_scanner_if.sv - request inputs and scanned display outputs of the message scanner
// Purpose: bundles the front-panel request lines and the 7-segment pin outputs.
// Ports (signals):
//   M, S0..S3, SR, SP, SN, VL : request lines (driven by master, read by scanner)
//   seg[6:0], h, an[DIGITS-1:0], frame : display pins (driven by scanner)
interface msg_display_scanner_if #(
    parameter int DIGITS = 4
);
    logic              M;
    logic              S0;
    logic              S1;
    logic              S2;
    logic              S3;
    logic              SR;
    logic              SP;
    logic              SN;
    logic              VL;
    logic [6:0]        seg;
    logic              h;
    logic [DIGITS-1:0] an;
    logic              frame;

    modport master (
        output M, S0, S1, S2, S3, SR, SP, SN, VL,
        input  seg, h, an, frame
    );

    modport slave (
        input  M, S0, S1, S2, S3, SR, SP, SN, VL,
        output seg, h, an, frame
    );
endinterface

// File: rtl/msg_display_scanner.sv
// rtl/msg_display_scanner.sv - priority message select with time-multiplexed 7-segment scan
// Purpose: picks one 4-character message from the request lines at each frame
// boundary and scans it right-aligned over DIGITS digits; fault messages blink.
// Ports:
//   CLK  : system clock
//   RST  : synchronous active-high reset
//   bus  : slave side of msg_display_scanner_if (requests in, seg/h/an/frame out)
module msg_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    msg_display_scanner_if.slave  bus
);
    localparam int   CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   PW  = $clog2(DIGITS);
    localparam int   BW  = $clog2(BLINK_FRAMES + 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic [3:0] {
        MSG_IDLE, MSG_ERSR, MSG_ERSP, MSG_ERSN, MSG_ERDL,
        MSG_CE01, MSG_CL02, MSG_CC05, MSG_CP10
    } msg_t;

    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_ptr;
    logic [BW-1:0]     r_bcnt;
    logic              r_phase;
    msg_t              r_msg;
    logic [6:0]        r_seg;
    logic              r_h;
    logic [DIGITS-1:0] r_an;
    logic              r_frame;

    logic              w_tick;
    logic              w_wrap;
    logic [PW-1:0]     w_ptr_nxt;
    msg_t              w_req_msg;
    msg_t              w_msg_nxt;
    logic [BW-1:0]     w_bcnt_nxt;
    logic              w_phase_nxt;
    logic [6:0]        w_seg;
    logic              w_h;
    logic [DIGITS-1:0] w_an;

    // Four glyphs packed leftmost-first, gfedcba per character.
    function automatic logic [6:0] char_glyph(input msg_t m, input logic [1:0] idx);
        logic [27:0] w;
        case (m)
            MSG_ERSR: w = {7'h79, 7'h50, 7'h6D, 7'h50};
            MSG_ERSP: w = {7'h79, 7'h50, 7'h6D, 7'h73};
            MSG_ERSN: w = {7'h79, 7'h50, 7'h6D, 7'h54};
            MSG_ERDL: w = {7'h79, 7'h50, 7'h5E, 7'h30};
            MSG_CE01: w = {7'h39, 7'h79, 7'h3F, 7'h06};
            MSG_CL02: w = {7'h39, 7'h38, 7'h3F, 7'h5B};
            MSG_CC05: w = {7'h39, 7'h39, 7'h3F, 7'h6D};
            MSG_CP10: w = {7'h39, 7'h73, 7'h06, 7'h3F};
            default:  w = 28'h0;
        endcase
        return w[7 * (3 - int'(idx)) +: 7];
    endfunction

    assign w_tick    = (r_cnt == CW'(DIV - 1));
    assign w_wrap    = w_tick && (r_ptr == PW'(DIGITS - 1));
    assign w_ptr_nxt = !w_tick ? r_ptr : (w_wrap ? '0 : r_ptr + PW'(1));
    assign w_msg_nxt = w_wrap ? w_req_msg : r_msg;

    always_comb begin
        w_req_msg = MSG_IDLE;
        if (!bus.M)       w_req_msg = MSG_IDLE;
        else if (bus.SR)  w_req_msg = MSG_ERSR;
        else if (bus.SP)  w_req_msg = MSG_ERSP;
        else if (bus.SN)  w_req_msg = MSG_ERSN;
        else if (bus.VL)  w_req_msg = MSG_ERDL;
        else if (bus.S0)  w_req_msg = MSG_CE01;
        else if (bus.S1)  w_req_msg = MSG_CL02;
        else if (bus.S2)  w_req_msg = MSG_CC05;
        else if (bus.S3)  w_req_msg = MSG_CP10;
    end

    // A changed message restarts the blink cycle in the ON phase.
    always_comb begin
        w_bcnt_nxt  = r_bcnt;
        w_phase_nxt = r_phase;
        if (w_wrap) begin
            if (w_req_msg != r_msg) begin
                w_bcnt_nxt  = '0;
                w_phase_nxt = 1'b1;
            end else if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
                w_bcnt_nxt  = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_bcnt_nxt  = r_bcnt + BW'(1);
            end
        end
    end

    // Outputs are computed from next-state values so they track ptr from the same edge.
    always_comb begin
        w_seg = 7'h00;
        w_h   = 1'b0;
        w_an  = DIGITS'(1) << w_ptr_nxt;
        if (w_msg_nxt == MSG_IDLE) begin
            w_h = 1'b1;
        end else if (int'(w_ptr_nxt) < DIGITS - 4) begin
            w_seg = 7'h00;
        end else if ((w_msg_nxt inside {MSG_ERSR, MSG_ERSP, MSG_ERSN, MSG_ERDL}) && !w_phase_nxt) begin
            w_seg = 7'h00;
        end else begin
            w_seg = char_glyph(w_msg_nxt, 2'(int'(w_ptr_nxt) - (DIGITS - 4)));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
            r_msg   <= MSG_IDLE;
            r_seg   <= {7{POL}};
            r_h     <= ~POL;
            r_an    <= DIGITS'(1) ^ {DIGITS{POL}};
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_ptr   <= w_ptr_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_phase <= w_phase_nxt;
            r_msg   <= w_msg_nxt;
            r_seg   <= w_seg ^ {7{POL}};
            r_h     <= w_h ^ POL;
            r_an    <= w_an ^ {DIGITS{POL}};
            r_frame <= w_wrap;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.h     = r_h;
    assign bus.an    = r_an;
    assign bus.frame = r_frame;
endmodule

// File: tb/tb_msg_display_scanner.sv
// tb/tb_msg_display_scanner.sv - self-checking bench for msg_display_scanner
module tb_msg_display_scanner;
    logic       clk;
    logic       rst;
    logic [8:0] req;   // {VL,SN,SP,SR,S3,S2,S1,S0,M}
    int         checks;
    int         errors;

    msg_display_scanner_if #(.DIGITS(4)) ifa ();
    msg_display_scanner_if #(.DIGITS(6)) ifb ();

    assign ifa.M  = req[0]; assign ifb.M  = req[0];
    assign ifa.S0 = req[1]; assign ifb.S0 = req[1];
    assign ifa.S1 = req[2]; assign ifb.S1 = req[2];
    assign ifa.S2 = req[3]; assign ifb.S2 = req[3];
    assign ifa.S3 = req[4]; assign ifb.S3 = req[4];
    assign ifa.SR = req[5]; assign ifb.SR = req[5];
    assign ifa.SP = req[6]; assign ifb.SP = req[6];
    assign ifa.SN = req[7]; assign ifb.SN = req[7];
    assign ifa.VL = req[8]; assign ifb.VL = req[8];

    msg_display_scanner #(.DIGITS(4), .DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(0)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa.slave));
    msg_display_scanner #(.DIGITS(6), .DIV(3), .BLINK_FRAMES(3), .ACTIVE_LOW(1)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges since reset, displayed message id, frames since it was latched.
    int dg [2] = '{4, 6};
    int dv [2] = '{4, 3};
    int bf [2] = '{2, 3};
    int al [2] = '{0, 1};
    int n  [2];
    int msg[2];
    int run[2];
    int fr [2];
    // id 0 = IDLE, 1..4 faults, 5..8 selections; glyphs leftmost first
    int gl [9][4] = '{
        '{'h00, 'h00, 'h00, 'h00},
        '{'h79, 'h50, 'h6D, 'h50},
        '{'h79, 'h50, 'h6D, 'h73},
        '{'h79, 'h50, 'h6D, 'h54},
        '{'h79, 'h50, 'h5E, 'h30},
        '{'h39, 'h79, 'h3F, 'h06},
        '{'h39, 'h38, 'h3F, 'h5B},
        '{'h39, 'h39, 'h3F, 'h6D},
        '{'h39, 'h73, 'h06, 'h3F}};

    function automatic int pick(input logic [8:0] r);
        if (!r[0]) return 0;
        if (r[5]) return 1;
        if (r[6]) return 2;
        if (r[7]) return 3;
        if (r[8]) return 4;
        if (r[1]) return 5;
        if (r[2]) return 6;
        if (r[3]) return 7;
        if (r[4]) return 8;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic [6:0] seg, input logic h,
                             input logic [5:0] an, input logic frame);
        int p, e_seg, e_h, e_an, mask;
        bit on;
        p    = (n[d] / dv[d]) % dg[d];
        on   = ((run[d] / bf[d]) % 2) == 0;
        mask = (1 << dg[d]) - 1;
        e_an = 1 << p;
        e_seg = 0;
        e_h   = 0;
        if (msg[d] == 0)                        e_h = 1;
        else if (p < dg[d] - 4)                 e_seg = 0;
        else if (msg[d] <= 4 && !on)            e_seg = 0;
        else                                    e_seg = gl[msg[d]][p - (dg[d] - 4)];
        if (al[d] != 0) begin
            e_seg = ~e_seg & 'h7F;
            e_h   = ~e_h & 1;
            e_an  = ~e_an & mask;
        end
        chk(d == 0 ? "a_an"    : "b_an",    32'(an),    32'(e_an));
        chk(d == 0 ? "a_seg"   : "b_seg",   32'(seg),   32'(e_seg));
        chk(d == 0 ? "a_h"     : "b_h",     32'(h),     32'(e_h));
        chk(d == 0 ? "a_frame" : "b_frame", 32'(frame), 32'(fr[d]));
    endtask

    task automatic step();
        int nm;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            fr[d] = 0;
            if (rst) begin
                n[d] = 0; msg[d] = 0; run[d] = 0;
            end else begin
                n[d]++;
                if (n[d] % (dv[d] * dg[d]) == 0) begin
                    fr[d] = 1;
                    nm = pick(req);
                    if (nm != msg[d]) begin
                        msg[d] = nm;
                        run[d] = 0;
                    end else begin
                        run[d]++;
                    end
                end
            end
        end
        @(negedge clk);
        check_dut(0, ifa.seg, ifa.h, 6'(ifa.an), ifa.frame);
        check_dut(1, ifb.seg, ifb.h, ifb.an, ifb.frame);
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = 9'h000;
        for (int d = 0; d < 2; d++) begin n[d] = 0; msg[d] = 0; run[d] = 0; fr[d] = 0; end

        run_cycles(3);                 // reset state
        rst = 1'b0;
        run_cycles(40);                // idle scan
        req = 9'b000000101;            // S1 mid-frame -> CL02
        run_cycles(50);
        req = 9'b001000011;            // S0 + SP -> ErSP with blinking
        run_cycles(150);
        req = 9'b001000010;            // M=0 forces idle
        run_cycles(40);
        req = 9'b001000011;            // M restored -> ErSP, phase ON
        run_cycles(40);
        req = 9'b000001001;            // S2 -> CC05
        run_cycles(45);
        rst = 1'b1;                    // reset mid-frame
        run_cycles(1);
        rst = 1'b0;
        run_cycles(40);

        for (int it = 0; it < 60; it++) begin
            logic [8:0] r;
            r[0] = ($urandom % 8) != 0;
            for (int b = 1; b <= 4; b++) r[b] = ($urandom % 3) == 0;
            for (int b = 5; b <= 8; b++) r[b] = ($urandom % 7) == 0;
            req = r;
            if ($urandom % 15 == 0) begin
                rst = 1'b1;
                run_cycles(1 + ($urandom % 2));
                rst = 1'b0;
            end
            run_cycles($urandom_range(1, 45));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
